// File: rtl/dbus_responder.sv
// dbus_responder: data-bus slave with a fixed-latency backing store.
//
// The core presents one request at a time on dreq. In IDLE, a valid request
// gets addr_ok in the same cycle and is captured at the next edge. The
// responder then counts LATENCY cycles and pulses data_ok for one cycle.
// For a read, dresp.data carries the whole aligned 64-bit word. A write
// updates the strobed bytes at the edge that ends the data_ok cycle.
// Addresses outside [BASE_ADDR, BASE_ADDR + 8*MEM_WORDS) keep the same
// timing. Reads of them return 0, writes to them are dropped, and each
// one bumps a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   dreq       request from the core: valid, addr, size, strobe, data
//   dresp      response to the core: addr_ok, data_ok, data
//   busy       high while a transaction is in flight (WAIT or RESP)
//   err_count  saturating count of out-of-range requests

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// One byte lane of the backing store. Reset does not touch the contents.
module dbus_mem_lane #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 512,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        busy,
  output logic [15:0] err_count
);
  localparam int NUM_LANES = 8;
  localparam int AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]    cnt;
  logic [AW-1:0] lat_idx;
  logic [7:0]    lat_strb;
  logic [63:0]   lat_data;
  logic          lat_oor;

  logic          accept;
  logic [63:0]   offset;
  logic          req_oor;
  logic          mem_we;

  logic [NUM_LANES-1:0][7:0] wr_bytes, rd_bytes;

  assign accept = (state == IDLE) && dreq.valid;

  // Range check on the incoming address. The subtraction wraps for
  // addresses below BASE_ADDR, so that case is tested separately.
  assign offset  = dreq.addr - BASE_ADDR;
  assign req_oor = (dreq.addr < BASE_ADDR) || (offset[63:3] >= 61'(MEM_WORDS));

  // size has no effect on behaviour. offset[2:0] selects a byte inside the
  // word, which is the core's job.
  logic unused_bits;
  assign unused_bits = ^{dreq.size, offset[2:0]};

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dreq.valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, latency counter and error counter. Only the word index
  // is kept from the address. Later changes on dreq are not seen until the
  // next IDLE.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_strb  <= '0;
      lat_data  <= '0;
      lat_oor   <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        cnt      <= 4'(LATENCY - 1);
        lat_idx  <= offset[AW+2:3];
        lat_strb <= dreq.strobe;
        lat_data <= dreq.data;
        lat_oor  <= req_oor;
        if (req_oor && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end

  // Outputs. addr_ok is gated by reset so nothing reaches the core while
  // reset is held. The write enable exists only in RESP. Because reset
  // forces IDLE at once, an aborted transaction cannot write the store.
  always_comb begin
    dresp         = '0;
    mem_we        = 1'b0;
    busy          = (state != IDLE);
    dresp.addr_ok = (state == IDLE) && dreq.valid && reset;
    if (state == RESP) begin
      dresp.data_ok = 1'b1;
      if ((lat_strb == 8'h00) && !lat_oor) dresp.data = rd_bytes;
      mem_we = (lat_strb != 8'h00) && !lat_oor;
    end
  end

  assign wr_bytes = lat_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dbus_mem_lane #(.DEPTH(MEM_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (mem_we & lat_strb[i]),
      .idx   (lat_idx),
      .wbyte (wr_bytes[i]),
      .rbyte (rd_bytes[i])
    );
  end
endmodule

// File: tb/tb_dbus_responder.sv
// Testbench for dbus_responder.
// It uses two instances: LATENCY=2 (dut2) and LATENCY=1 (dut1).
// A reference model holds the memory and error count as plain arrays and
// integers, and the bench checks each observed response against it.
module tb_dbus_responder;
  import dbus_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          WORDS = 512;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dbus_req_t  dreq, dreq2, dreq1;
  dbus_resp_t resp2, resp1, rs;
  logic       busy2, busy1, bsy;
  logic [15:0] err2, err1;
  logic       sel = 1'b0;   // 0 drives dut2, 1 drives dut1

  always_comb begin
    dreq2       = dreq;
    dreq2.valid = dreq.valid & ~sel;
    dreq1       = dreq;
    dreq1.valid = dreq.valid & sel;
  end
  assign rs  = sel ? resp1 : resp2;
  assign bsy = sel ? busy1 : busy2;

  dbus_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .dreq(dreq2), .dresp(resp2), .busy(busy2), .err_count(err2));
  dbus_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(resp1), .busy(busy1), .err_count(err1));

  int checks = 0;
  int failures = 0;
  int exp_err2 = 0;
  longint cyc = 0;
  logic [63:0] m2 [WORDS];
  logic [63:0] m1 [WORDS];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * WORDS));
  endfunction

  function automatic int widx(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) >> 3;
    return int'(o);
  endfunction

  task automatic model_txn(input bit s, input logic [63:0] a, input logic [7:0] st,
                           input logic [63:0] d, output logic [63:0] expv);
    int w;
    expv = '0;
    if (!in_rng(a)) begin
      if (!s && exp_err2 < 65535) exp_err2++;
      return;
    end
    w = widx(a);
    if (st == 8'h00) expv = s ? m1[w] : m2[w];
    else
      for (int i = 0; i < 8; i++)
        if (st[i]) begin
          if (s) m1[w][8*i +: 8] = d[8*i +: 8];
          else   m2[w][8*i +: 8] = d[8*i +: 8];
        end
  endtask

  // ---------------- bus driver ----------------
  // Call this from IDLE, #1 after a rising edge. It returns:
  //   aok    addr_ok in the request cycle
  //   lat    number of cycles from the request cycle to data_ok (0 = none)
  //   rd     dresp.data in the data_ok cycle
  //   tok    cycle stamp of data_ok
  //   clean  busy, addr_ok and data_ok behaved as required around the transfer
  task automatic bus_txn(input bit s, input logic [63:0] a, input logic [7:0] st,
                         input logic [63:0] d, input bit perturb, input logic [63:0] alt,
                         input bit keep, output bit aok, output int lat,
                         output logic [63:0] rd, output longint tok, output bit clean);
    sel = s;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = 3'($urandom);
    dreq.strobe = st;
    dreq.data   = d;
    @(negedge clk);
    aok   = rs.addr_ok;
    clean = !rs.data_ok && !bsy;
    @(posedge clk); #1;
    if (perturb) begin
      dreq.addr   = alt;
      dreq.strobe = 8'($urandom);
      dreq.data   = {$urandom, $urandom};
      dreq.valid  = 1'($urandom_range(0, 1));
    end
    lat = 0; rd = '0; tok = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!bsy || rs.addr_ok) clean = 1'b0;
      if (rs.data_ok) begin lat = n; rd = rs.data; tok = cyc; break; end
    end
    @(posedge clk); #1;
    if (rs.data_ok || bsy) clean = 1'b0;
    if (!keep) dreq.valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit aok, cl; int lat; logic [63:0] rd; longint t;
    dreq = '0; dreq.valid = 1'b1; dreq.addr = BASE;
    #3;
    checks++; if (resp2 !== '0) begin failures++; $display("FAIL reset_resp2 got=%h exp=0", resp2); end
    checks++; if (resp1 !== '0) begin failures++; $display("FAIL reset_resp1 got=%h exp=0", resp1); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy2); end
    checks++; if (err2 !== 16'h0) begin failures++; $display("FAIL reset_err got=%h exp=0", err2); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    // The first cycle out of reset must already accept a request.
    bus_txn(0, BASE, 8'hFF, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    model_txn(0, BASE, 8'hFF, 64'h0, rd);
    checks++; if (aok !== 1'b1 || lat !== 2 || cl !== 1'b1)
      begin failures++; $display("FAIL first_accept aok=%b lat=%0d clean=%b exp 1/2/1", aok, lat, cl); end
  endtask

  task automatic test_preload();
    bit aok, cl; int lat; logic [63:0] rd, e, d; longint t;
    for (int w = 0; w < WORDS; w++) begin
      d = {$urandom, $urandom};
      bus_txn(0, BASE + 64'(8 * w), 8'hFF, d, 0, 64'h0, 0, aok, lat, rd, t, cl);
      model_txn(0, BASE + 64'(8 * w), 8'hFF, d, e);
      checks++; if (lat !== 2 || rd !== 64'h0)
        begin failures++; $display("FAIL preload2 w=%0d lat=%0d data=%h exp lat=2 data=0", w, lat, rd); end
    end
    for (int w = 0; w < 8; w++) begin
      d = {$urandom, $urandom};
      bus_txn(1, BASE + 64'(8 * w), 8'hFF, d, 0, 64'h0, 0, aok, lat, rd, t, cl);
      model_txn(1, BASE + 64'(8 * w), 8'hFF, d, e);
      checks++; if (lat !== 1 || aok !== 1'b1 || cl !== 1'b1)
        begin failures++; $display("FAIL preload1 w=%0d lat=%0d aok=%b clean=%b exp 1/1/1", w, lat, aok, cl); end
    end
  endtask

  task automatic test_basic_read();
    bit aok, cl; int lat; logic [63:0] rd, e; longint t;
    bus_txn(0, BASE, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0, 0, aok, lat, rd, t, cl);
    model_txn(0, BASE, 8'hFF, 64'h1122_3344_5566_7788, e);
    bus_txn(0, BASE, 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    checks++; if (aok !== 1'b1) begin failures++; $display("FAIL basic_addr_ok got=%b exp=1", aok); end
    checks++; if (lat !== 2 || cl !== 1'b1)
      begin failures++; $display("FAIL basic_timing lat=%0d clean=%b exp lat=2 clean=1", lat, cl); end
    checks++; if (rd !== 64'h1122_3344_5566_7788)
      begin failures++; $display("FAIL basic_data got=%h exp=1122334455667788", rd); end
  endtask

  task automatic test_strobe_write();
    bit aok, cl; int lat; logic [63:0] rd, e; longint t;
    bus_txn(0, BASE + 8, 8'hFF, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    model_txn(0, BASE + 8, 8'hFF, 64'h0, e);
    bus_txn(0, BASE + 8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 0, 64'h0, 0, aok, lat, rd, t, cl);
    model_txn(0, BASE + 8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, e);
    checks++; if (rd !== 64'h0 || lat !== 2)
      begin failures++; $display("FAIL strobe_wr_resp data=%h lat=%0d exp data=0 lat=2", rd, lat); end
    bus_txn(0, BASE + 8, 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    checks++; if (rd !== 64'h0000_0000_BBBB_BBBB)
      begin failures++; $display("FAIL strobe_rd got=%h exp=00000000bbbbbbbb", rd); end
  endtask

  task automatic test_out_of_range();
    bit aok, cl; int lat; logic [63:0] rd, e; longint t;
    bus_txn(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    model_txn(0, 64'h7FFF_FFF8, 8'h00, 64'h0, e);
    checks++; if (rd !== 64'h0 || lat !== 2 || cl !== 1'b1)
      begin failures++; $display("FAIL oor_read data=%h lat=%0d clean=%b exp 0/2/1", rd, lat, cl); end
    bus_txn(0, BASE + 64'(8 * WORDS), 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0, 0, aok, lat, rd, t, cl);
    model_txn(0, BASE + 64'(8 * WORDS), 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, e);
    checks++; if (lat !== 2 || aok !== 1'b1)
      begin failures++; $display("FAIL oor_write lat=%0d aok=%b exp 2/1", lat, aok); end
    checks++; if (err2 !== 16'd2) begin failures++; $display("FAIL oor_err_count got=%0d exp=2", err2); end
    bus_txn(0, BASE, 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    checks++; if (rd !== m2[0]) begin failures++; $display("FAIL oor_word0 got=%h exp=%h", rd, m2[0]); end
    bus_txn(0, BASE + 64'(8 * (WORDS - 1)), 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    checks++; if (rd !== m2[WORDS-1])
      begin failures++; $display("FAIL oor_wordlast got=%h exp=%h", rd, m2[WORDS-1]); end
  endtask

  task automatic test_back_to_back();
    bit aok, cl; int lat; logic [63:0] rd, e; longint t0, t1;
    int w;
    w = $urandom_range(0, WORDS - 1);
    bus_txn(0, BASE + 64'(8 * w), 8'h00, 64'h0, 0, 64'h0, 1, aok, lat, rd, t0, cl);
    model_txn(0, BASE + 64'(8 * w), 8'h00, 64'h0, e);
    checks++; if (rd !== e) begin failures++; $display("FAIL b2b_data0 got=%h exp=%h", rd, e); end
    for (int k = 1; k <= 3; k++) begin
      w = $urandom_range(0, WORDS - 1);
      bus_txn(0, BASE + 64'(8 * w), 8'h00, 64'h0, 0, 64'h0, (k != 3), aok, lat, rd, t1, cl);
      model_txn(0, BASE + 64'(8 * w), 8'h00, 64'h0, e);
      checks++; if (t1 - t0 !== 64'd3 || aok !== 1'b1)
        begin failures++; $display("FAIL b2b_spacing k=%0d got=%0d exp=3 aok=%b", k, t1 - t0, aok); end
      checks++; if (rd !== e) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rd, e); end
      t0 = t1;
    end
  endtask

  task automatic test_random();
    bit aok, cl; int lat; logic [63:0] rd, e, a, d; logic [7:0] st; longint t;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 64'($urandom_range(1, 4000));
        1:       a = BASE + 64'(8 * WORDS) + 64'($urandom_range(0, 4000));
        default: a = BASE + 64'($urandom_range(0, 8 * WORDS - 1));
      endcase
      st = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
      d  = {$urandom, $urandom};
      bus_txn(0, a, st, d, 1'($urandom_range(0, 1)), BASE + 64'($urandom_range(0, 8 * WORDS - 1)),
              0, aok, lat, rd, t, cl);
      model_txn(0, a, st, d, e);
      checks++; if (lat !== 2 || aok !== 1'b1 || cl !== 1'b1)
        begin failures++; $display("FAIL rand_timing n=%0d lat=%0d aok=%b clean=%b exp 2/1/1", n, lat, aok, cl); end
      checks++; if (rd !== e)
        begin failures++; $display("FAIL rand_data n=%0d addr=%h st=%h got=%h exp=%h", n, a, st, rd, e); end
    end
    checks++; if (err2 !== 16'(exp_err2))
      begin failures++; $display("FAIL rand_err_count got=%0d exp=%0d", err2, exp_err2); end
  endtask

  task automatic test_reset_abort();
    bit aok, cl, seen; int lat; logic [63:0] rd; longint t;
    // dut2: reset lands in WAIT.
    sel = 1'b0; seen = 1'b0;
    dreq.valid = 1'b1; dreq.addr = BASE + 40; dreq.strobe = 8'hFF; dreq.data = ~m2[5];
    @(negedge clk);
    @(posedge clk); #1 dreq.valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy2); end
    checks++; if (resp2.data_ok !== 1'b0) begin failures++; $display("FAIL abort_data_ok got=%b exp=0", resp2.data_ok); end
    repeat (3) begin @(negedge clk); if (resp2.data_ok) seen = 1'b1; end
    @(posedge clk); #1 reset = 1'b1;
    exp_err2 = 0;
    repeat (3) begin @(negedge clk); if (resp2.data_ok) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_data_ok got=%b exp=0", seen); end
    checks++; if (err2 !== 16'(exp_err2)) begin failures++; $display("FAIL abort_err got=%0d exp=%0d", err2, exp_err2); end
    @(posedge clk); #1;
    bus_txn(0, BASE + 40, 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    checks++; if (rd !== m2[5]) begin failures++; $display("FAIL abort_word got=%h exp=%h", rd, m2[5]); end
    // dut1: reset lands in RESP.
    sel = 1'b1;
    dreq.valid = 1'b1; dreq.addr = BASE + 16; dreq.strobe = 8'hFF; dreq.data = ~m1[2];
    @(negedge clk);
    @(posedge clk); #1 dreq.valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || resp1.data_ok !== 1'b0)
      begin failures++; $display("FAIL abort_resp busy=%b data_ok=%b exp 0/0", busy1, resp1.data_ok); end
    @(posedge clk); #1 reset = 1'b1;
    bus_txn(1, BASE + 16, 8'h00, 64'h0, 0, 64'h0, 0, aok, lat, rd, t, cl);
    checks++; if (rd !== m1[2]) begin failures++; $display("FAIL abort_resp_word got=%h exp=%h", rd, m1[2]); end
  endtask

  task automatic test_lat1();
    bit aok, cl; int lat; logic [63:0] rd, e, d; longint t;
    bus_txn(1, BASE + 24, 8'h00, 64'h0, 1, BASE + 32, 0, aok, lat, rd, t, cl);
    model_txn(1, BASE + 24, 8'h00, 64'h0, e);
    checks++; if (lat !== 1 || aok !== 1'b1 || cl !== 1'b1)
      begin failures++; $display("FAIL lat1_timing lat=%0d aok=%b clean=%b exp 1/1/1", lat, aok, cl); end
    checks++; if (rd !== e) begin failures++; $display("FAIL lat1_data got=%h exp=%h", rd, e); end
    for (int n = 0; n < 20; n++) begin
      logic [63:0] a; logic [7:0] st;
      a  = BASE + 64'($urandom_range(0, 63));
      st = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
      d  = {$urandom, $urandom};
      bus_txn(1, a, st, d, 1, BASE + 64'($urandom_range(0, 63)), 0, aok, lat, rd, t, cl);
      model_txn(1, a, st, d, e);
      checks++; if (lat !== 1 || rd !== e)
        begin failures++; $display("FAIL lat1_rand n=%0d lat=%0d got=%h exp=%h", n, lat, rd, e); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_read();
    test_strobe_write();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
